// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte-buffering front end for a UART transmitter that has no busy output.
//   Bytes are queued in a small synchronous FIFO and handed to the transmitter
//   one at a time with a fixed-width tx_ready pulse. The block waits a fixed
//   frame time between pulses so the transmitter always finishes a frame first.
//
//   Ports:
//     sys_clk_50M  in   system clock
//     rst          in   synchronous reset, active-high
//     wr_en        in   enqueue wr_data this cycle
//     wr_data      in   byte to enqueue
//     full         out  FIFO holds DEPTH bytes
//     empty        out  FIFO holds 0 bytes
//     level        out  FIFO occupancy, 0..DEPTH
//     busy         out  high whenever the FSM is not in IDLE
//     tx_ready     out  launch pulse, PULSE_LEN cycles high per byte
//     tx_data      out  byte for the transmitter, held from pulse rise onward
//
//   Optional build macro UART_TX_FEEDER_OVF_EN adds:
//     ovf          out  sticky: a write arrived while full (cleared by rst only)
//     drop_cnt     out  saturating count of dropped bytes
//
//   state | meaning
//   IDLE  | waiting for a queued byte; pops the FIFO head when level != 0
//   LOAD  | popped byte moves to tx_data, tx_ready rises, frame counter clears
//   PULSE | tx_ready held high for PULSE_LEN cycles
//   WAIT  | tx_ready low; remainder of the frame time
module uart_tx_feeder #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int PULSE_LEN = 4,
  parameter int FRAME_CYC = 52096
) (
  input  logic          sys_clk_50M,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          busy,
  output logic          tx_ready,
  output logic [7:0]    tx_data
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  output logic          ovf,
  output logic [7:0]    drop_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, PULSE, WAIT} state_t;

  localparam logic [16:0] PULSE_LAST = 17'(PULSE_LEN - 1);
  // The counter steps to FRAME_CYC-2 on the same edge that returns to IDLE;
  // IDLE + LOAD then add the two cycles that make the rise-to-rise spacing
  // exactly FRAME_CYC.
  localparam logic [16:0] WAIT_LAST  = 17'(FRAME_CYC - 3);
  localparam logic [AW:0] LVL_FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0] LVL_ZERO   = '0;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    pop_data;
  logic [16:0]   frame_cnt;
  logic [AW:0]   level_nxt;
  logic          push, pop;

  // Full is judged on the current level: a same-cycle pop frees no space.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && (level != LVL_ZERO);
  assign busy = (state != IDLE);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LOAD;
      LOAD:    state_nxt = PULSE;
      PULSE:   if (frame_cnt >= PULSE_LAST) state_nxt = WAIT;
      WAIT:    if (frame_cnt >= WAIT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_50M) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk_50M) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      pop_data  <= 8'h00;
      tx_data   <= 8'h00;
      tx_ready  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      full     <= (level_nxt == LVL_FULL);
      empty    <= (level_nxt == LVL_ZERO);
      tx_ready <= (state_nxt == PULSE);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      if (state == LOAD) begin
        tx_data   <= pop_data;
        frame_cnt <= '0;
      end else if ((state == PULSE || state == WAIT) && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 17'd1;
      end
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  always_ff @(posedge sys_clk_50M) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a short frame time (FRAME_CYC=600).
module tb_uart_tx_feeder;

  localparam int F  = 600;
  localparam int PL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, tx_ready;
  logic [4:0] level;
  logic [7:0] tx_data;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       ovf;
  logic [7:0] drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int n;

  uart_tx_feeder #(.DEPTH(16), .AW(4), .PULSE_LEN(PL), .FRAME_CYC(F)) dut (
    .sys_clk_50M(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .level(level),
    .busy(busy),
    .tx_ready(tx_ready),
    .tx_data(tx_data)
`ifdef UART_TX_FEEDER_OVF_EN
    ,
    .ovf(ovf),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Returns the number of cycles until the next 0->1 of tx_ready; max+1 on timeout.
  task automatic wait_rise(input int max_cyc, output int cnt);
    logic prev;
    prev = tx_ready;
    for (cnt = 1; cnt <= max_cyc; cnt++) begin
      tick();
      if (tx_ready && !prev) break;
      prev = tx_ready;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_tx_ready", tx_ready, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
`ifdef UART_TX_FEEDER_OVF_EN
    check("rst_ovf", ovf, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // single byte: visible at t+3, 4-cycle pulse, busy for the frame
    write_byte(8'hA5);
    check("a5_level", level, 1);
    wait_rise(10, n);
    check("a5_latency", n, 2);
    check("a5_data", tx_data, 8'hA5);
    check("a5_busy", busy, 1);
    for (int i = 1; i < PL; i++) begin
      tick();
      check("a5_pulse_hi", tx_ready, 1);
    end
    tick();
    check("a5_pulse_lo", tx_ready, 0);
    repeat (F - 7) tick();
    check("a5_busy_end", busy, 1);
    tick();
    check("a5_idle", busy, 0);
    check("a5_hold", tx_data, 8'hA5);
    check("a5_empty", empty, 1);

    // burst of three: third write lands on the first rise
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check("b1_ready", tx_ready, 1);
    check("b1_data", tx_data, 8'h01);
    check("b1_level", level, 2);
    wait_rise(F + 50, n);
    check("b2_spacing", n, F);
    check("b2_data", tx_data, 8'h02);
    wait_rise(F + 50, n);
    check("b3_spacing", n, F);
    check("b3_data", tx_data, 8'h03);
    check("b3_empty", empty, 1);
    check("b3_level", level, 0);

    // fill to 16, 17th byte dropped
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_level", level, 16);
`ifdef UART_TX_FEEDER_OVF_EN
    check("fill_ovf_clear", ovf, 0);
`endif
    write_byte(8'h10);
    check("drop_level", level, 16);
    check("drop_full", full, 1);
`ifdef UART_TX_FEEDER_OVF_EN
    check("drop_ovf", ovf, 1);
    check("drop_cnt", drop_cnt, 1);
`endif

    // drain 00..0F across the pointer wrap; write+pop at level 5 after 0A
    for (int k = 0; k < 16; k++) begin
      wait_rise(F + 50, n);
      check("drain_spacing", n, (k == 0) ? 583 : ((k == 11) ? 1 : F));
      check("drain_data", tx_data, k);
      if (k == 0) check("drain_not_full", full, 0);
      if (k == 10) begin
        check("wp_level_pre", level, 5);
        repeat (F - 2) tick();
        check("wp_idle", busy, 0);
        check("wp_level_idle", level, 5);
        write_byte(8'h77);
        check("wp_level_post", level, 5);
      end
    end
    wait_rise(F + 50, n);
    check("last_spacing", n, F);
    check("last_data", tx_data, 8'h77);
    check("last_empty", empty, 1);

    // reset during PULSE with 4 queued bytes
    write_byte(8'hAA);
    write_byte(8'hBB);
    write_byte(8'hCC);
    write_byte(8'hDD);
    wait_rise(F + 50, n);
    check("pre_spacing", n, F - 4);
    check("pre_data", tx_data, 8'hAA);
    write_byte(8'hEE);
    check("pre_ready", tx_ready, 1);
    check("pre_level", level, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", tx_ready, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", tx_data, 8'h00);
    write_byte(8'h3C);
    wait_rise(10, n);
    check("post_rst_latency", n, 2);
    check("post_rst_data", tx_data, 8'h3C);
    check("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
